// File: rtl/urng_sched_pkg.sv
// Shared types and constants for the uniform random word scheduler.
package urng_sched_pkg;

  typedef enum logic [1:0] {
    ST_SEED = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Seed expansion: each component gets a different view of the seed word.
  localparam logic [31:0] SEED_XOR1  = 32'h10850089;
  localparam logic [31:0] SEED_XOR2  = 32'h89305309;

  // A component below its bound would degenerate, so it is nudged upward.
  localparam logic [31:0] BOUND0     = 32'd2;
  localparam logic [31:0] BOUND1     = 32'd8;
  localparam logic [31:0] BOUND2     = 32'd16;
  localparam logic [31:0] SEED_FIXUP = 32'h00000100;

  // Tausworthe component masks.
  localparam logic [31:0] MASK0      = 32'hFFFFFFFE;
  localparam logic [31:0] MASK1      = 32'hFFFFFFF8;
  localparam logic [31:0] MASK2      = 32'hFFFFFFF0;

  function automatic logic [31:0] fix_seed(input logic [31:0] v, input logic [31:0] bound);
    return (v < bound) ? (v | SEED_FIXUP) : v;
  endfunction

endpackage

// File: rtl/urng_step.sv
// Three-component Tausworthe generator state with seed load and step enable.
// word is the output of the state the next step will store.
module urng_step
  import urng_sched_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] seed,
  output logic [31:0] word
);

  logic [31:0] s0, s1, s2;
  logic [31:0] n0, n1, n2;

  // Next state of each component and the word it produces.
  always_comb begin
    n0   = ((s0 & MASK0) << 12) ^ (((s0 << 13) ^ s0) >> 19);
    n1   = ((s1 & MASK1) << 4)  ^ (((s1 << 2)  ^ s1) >> 25);
    n2   = ((s2 & MASK2) << 17) ^ (((s2 << 3)  ^ s2) >> 11);
    word = n0 ^ n1 ^ n2;
  end

  // Component registers: seeding wins over stepping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0 <= '0;
      s1 <= '0;
      s2 <= '0;
    end else if (load) begin
      s0 <= fix_seed(seed, BOUND0);
      s1 <= fix_seed(seed ^ SEED_XOR1, BOUND1);
      s2 <= fix_seed(seed ^ SEED_XOR2, BOUND2);
    end else if (step) begin
      s0 <= n0;
      s1 <= n1;
      s2 <= n2;
    end
  end

endmodule

// File: rtl/urng_sched.sv
// Seeds and warms the generator, then hands words to two requesters through
// one output register each, sharing a single word per cycle round-robin.
//
// Handshake: outN_valid says outN_data holds an undelivered word; the word is
// delivered on a rising edge where outN_valid and outN_ready are both high.
// While valid is high and ready is low, data and valid hold. A slot may be
// refilled in the same cycle its word is delivered.
module urng_sched
  import urng_sched_pkg::*;
#(
  parameter int unsigned WARMUP   = 16,
  parameter bit          ROT_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] seed,
  input  logic        seed_load,
  output logic        busy,
  output logic [31:0] out0_data,
  output logic [31:0] out1_data,
  output logic        out0_valid,
  output logic        out1_valid,
  input  logic        out0_ready,
  input  logic        out1_ready,
  output logic [15:0] gen_count,
  output state_t      fsm_state
);

  localparam logic [7:0] WARM_LAST = 8'(WARMUP - 1);

  state_t      state, state_next;
  logic [7:0]  warm_cnt;
  logic        rr, rr_next;
  logic        load, step;
  logic        fill0, fill1;
  logic        free0, free1;
  logic        deliv0, deliv1;
  logic [31:0] word;

  urng_step u_step (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .step  (step),
    .seed  (seed),
    .word  (word)
  );

  assign free0     = !out0_valid || out0_ready;
  assign free1     = !out1_valid || out1_ready;
  assign deliv0    = out0_valid && out0_ready;
  assign deliv1    = out1_valid && out1_ready;
  assign busy      = (state != ST_RUN);
  assign fsm_state = state;

  // State, priority and warm-up counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_SEED;
      rr       <= ROT_INIT;
      warm_cnt <= '0;
    end else begin
      state    <= state_next;
      rr       <= rr_next;
      if (state == ST_SEED)      warm_cnt <= '0;
      else if (state == ST_WARM) warm_cnt <= warm_cnt + 8'd1;
    end
  end

  // Next state, generator control and slot selection; reseed overrides all.
  always_comb begin
    state_next = state;
    rr_next    = rr;
    load       = 1'b0;
    step       = 1'b0;
    fill0      = 1'b0;
    fill1      = 1'b0;
    case (state)
      ST_SEED: begin
        load       = 1'b1;
        state_next = ST_WARM;
      end
      ST_WARM: begin
        step = 1'b1;
        if (warm_cnt == WARM_LAST) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (free0 && free1) begin
          step    = 1'b1;
          fill0   = !rr;
          fill1   = rr;
          rr_next = !rr;
        end else if (free0 || free1) begin
          step  = 1'b1;
          fill0 = free0;
          fill1 = free1;
        end
      end
      default: state_next = ST_SEED;
    endcase
    if (seed_load) begin
      state_next = ST_SEED;
      step       = 1'b0;
      fill0      = 1'b0;
      fill1      = 1'b0;
      rr_next    = rr;
    end
  end

  // Output slots and the delivered-word counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out0_valid <= 1'b0;
      out1_valid <= 1'b0;
      out0_data  <= '0;
      out1_data  <= '0;
      gen_count  <= '0;
    end else begin
      gen_count <= gen_count + 16'(deliv0) + 16'(deliv1);
      if (seed_load)  out0_valid <= 1'b0;
      else if (fill0) out0_valid <= 1'b1;
      else if (deliv0) out0_valid <= 1'b0;
      if (seed_load)  out1_valid <= 1'b0;
      else if (fill1) out1_valid <= 1'b1;
      else if (deliv1) out1_valid <= 1'b0;
      if (fill0) out0_data <= word;
      if (fill1) out1_data <= word;
    end
  end

endmodule

// File: tb/tb_urng_sched.sv
// Directed bench for urng_sched with a golden Tausworthe model feeding an
// expected-word queue.
module tb_urng_sched;
  import urng_sched_pkg::*;

  localparam int          WARMUP   = 16;
  localparam bit          ROT_INIT = 1'b0;

  logic        clk;
  logic        reset;
  logic [31:0] seed;
  logic        seed_load;
  logic        busy;
  logic [31:0] out0_data, out1_data;
  logic        out0_valid, out1_valid;
  logic        out0_ready, out1_ready;
  logic [15:0] gen_count;
  state_t      fsm_state;

  urng_sched #(.WARMUP(WARMUP), .ROT_INIT(ROT_INIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .seed       (seed),
    .seed_load  (seed_load),
    .busy       (busy),
    .out0_data  (out0_data),
    .out1_data  (out1_data),
    .out0_valid (out0_valid),
    .out1_valid (out1_valid),
    .out0_ready (out0_ready),
    .out1_ready (out1_ready),
    .gen_count  (gen_count),
    .fsm_state  (fsm_state)
  );

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m0, m1, m2;
  logic [15:0] exp_cnt;
  int          tot_del;
  logic [31:0] slot0_exp, slot1_exp;
  logic        pv0, pr0, pv1, pr1, psl;
  int          new_port;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tw(input logic [31:0] s, input int a, input int b,
                                     input int c, input logic [31:0] m);
    logic [31:0] t;
    t = ((s << a) ^ s) >> b;
    return ((s & m) << c) ^ t;
  endfunction

  task automatic model_fill(input int n);
    repeat (n) begin
      m0 = tw(m0, 13, 19, 12, 32'hFFFFFFFE);
      m1 = tw(m1, 2, 25, 4, 32'hFFFFFFF8);
      m2 = tw(m2, 3, 11, 17, 32'hFFFFFFF0);
      exp_q.push_back(m0 ^ m1 ^ m2);
    end
  endtask

  // Seed the golden model, discard the warm-up words, restart the queue.
  task automatic model_seed(input logic [31:0] sd);
    m0 = sd;
    m1 = sd ^ 32'h10850089;
    m2 = sd ^ 32'h89305309;
    if (m0 < 2)  m0 = m0 | 32'h100;
    if (m1 < 8)  m1 = m1 | 32'h100;
    if (m2 < 16) m2 = m2 | 32'h100;
    model_fill(WARMUP);
    exp_q.delete();
  endtask

  // Scoreboard check after each rising edge, sampled on the falling edge.
  task automatic monitor();
    logic n0, n1;
    logic [31:0] e;
    exp_cnt = exp_cnt + 16'(pv0 & pr0) + 16'(pv1 & pr1);
    tot_del = tot_del + int'(pv0 & pr0) + int'(pv1 & pr1);
    chk("gen_count", 32'(gen_count), 32'(exp_cnt));
    n0 = out0_valid && (!pv0 || pr0) && !psl;
    n1 = out1_valid && (!pv1 || pr1) && !psl;
    chk("one_fill_per_cycle", 32'(n0 & n1), 32'd0);
    new_port = n0 ? 0 : (n1 ? 1 : 2);
    if (n0) begin
      if (exp_q.size() == 0) model_fill(32);
      e = exp_q.pop_front();
      slot0_exp = e;
      chk("word_out0", out0_data, e);
    end
    if (n1) begin
      if (exp_q.size() == 0) model_fill(32);
      e = exp_q.pop_front();
      slot1_exp = e;
      chk("word_out1", out1_data, e);
    end
    if (pv0 && !pr0 && !psl) begin
      chk("hold_valid0", 32'(out0_valid), 32'd1);
      chk("hold_data0", out0_data, slot0_exp);
    end
    if (pv1 && !pr1 && !psl) begin
      chk("hold_valid1", 32'(out1_valid), 32'd1);
      chk("hold_data1", out1_data, slot1_exp);
    end
  endtask

  task automatic tick();
    pv0 = out0_valid;
    pr0 = out0_ready;
    pv1 = out1_valid;
    pr1 = out1_ready;
    psl = seed_load;
    @(posedge clk);
    @(negedge clk);
    monitor();
  endtask

  task automatic chk_reset_vals();
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_state", 32'(fsm_state), 32'(ST_SEED));
    chk("rst_valid0", 32'(out0_valid), 32'd0);
    chk("rst_valid1", 32'(out1_valid), 32'd0);
    chk("rst_data0", out0_data, 32'd0);
    chk("rst_data1", out1_data, 32'd0);
    chk("rst_gen_count", 32'(gen_count), 32'd0);
    chk("rst_s0", dut.u_step.s0, 32'd0);
  endtask

  // After reset release: SEED plus WARMUP warm cycles busy, no words.
  task automatic release_sequence();
    for (int i = 1; i <= WARMUP + 1; i++) begin
      tick();
      chk("busy_after_release", 32'(busy), 32'(i <= WARMUP));
      chk("no_valid0_warm", 32'(out0_valid), 32'd0);
      chk("no_valid1_warm", 32'(out1_valid), 32'd0);
    end
  endtask

  task automatic run_alternate(input int n, input int start);
    int ep;
    ep = start;
    repeat (n) begin
      tick();
      chk("alternate_port", 32'(new_port), 32'(ep));
      ep = 1 - ep;
    end
  endtask

  initial begin
    int guard;
    logic [15:0] prev_gc;
    logic saw_wrap;

    reset = 1'b0;
    seed = 32'h12345678;
    seed_load = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    exp_cnt = '0;
    tot_del = 0;
    slot0_exp = '0;
    slot1_exp = '0;
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals();

    // Release reset and warm up from 0x12345678.
    reset = 1'b1;
    model_seed(seed);
    release_sequence();

    // Both requesters ready: words alternate from the reset priority owner.
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    run_alternate(21, int'(ROT_INIT));

    // Requester 0 stalls with a word held; requester 1 takes every word.
    out0_ready = 1'b0;
    repeat (10) begin
      tick();
      chk("stall_fill_port1", 32'(new_port), 32'd1);
    end

    // Random backpressure on both ports.
    for (int i = 0; i < 200; i++) begin
      out0_ready = 1'($urandom_range(0, 1));
      out1_ready = 1'($urandom_range(0, 1));
      tick();
    end

    // Reseed in RUN with pending words; a second request in SEED resamples.
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    seed = 32'hDEADBEEF;
    seed_load = 1'b1;
    tick();
    chk("reseed_valid0", 32'(out0_valid), 32'd0);
    chk("reseed_valid1", 32'(out1_valid), 32'd0);
    chk("reseed_busy", 32'(busy), 32'd1);
    chk("reseed_state", 32'(fsm_state), 32'(ST_SEED));
    seed = 32'h00000000;
    tick();
    chk("reseed_again_state", 32'(fsm_state), 32'(ST_SEED));
    seed_load = 1'b0;
    tick();
    chk("seed0_s0", dut.u_step.s0, 32'h00000100);
    chk("seed0_s1", dut.u_step.s1, 32'h10850089);
    chk("seed0_s2", dut.u_step.s2, 32'h89305309);
    chk("seed0_busy", 32'(busy), 32'd1);
    model_seed(32'h00000000);
    for (int i = 1; i <= WARMUP; i++) begin
      tick();
      chk("reseed_warm_busy", 32'(busy), 32'(i < WARMUP));
    end
    for (int i = 0; i < 150; i++) begin
      out0_ready = 1'($urandom_range(0, 1));
      out1_ready = 1'($urandom_range(0, 1));
      tick();
    end

    // Asynchronous reset in the middle of WARM.
    seed = 32'hCAFEF00D;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    repeat (6) tick();
    chk("mid_warm_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals();
    exp_cnt = '0;
    tot_del = 0;
    slot0_exp = '0;
    slot1_exp = '0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_seed(seed);
    release_sequence();
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    run_alternate(8, int'(ROT_INIT));

    // Deliver 65537 words since reset and watch the counter wrap.
    guard = 0;
    saw_wrap = 1'b0;
    while (tot_del < 65537 && guard < 70000) begin
      prev_gc = gen_count;
      tick();
      if (prev_gc == 16'hFFFF && gen_count == 16'h0000) saw_wrap = 1'b1;
      guard++;
    end
    chk("wrap_deliveries", 32'(tot_del), 32'd65537);
    chk("wrap_seen", 32'(saw_wrap), 32'd1);
    chk("wrap_gen_count", 32'(gen_count), 32'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/urng_sched.md
URNG_SCHED -- requirements
Module: urng_sched

Interface
REQ-001 Parameter WARMUP, 16: number of generator steps discarded after every seeding (1..255).
REQ-002 Parameter ROT_INIT, 0: requester index that owns round-robin priority after reset (0 or 1).
REQ-003 Port clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Port reset  in  1  asynchronous, active-low reset.
REQ-005 Port seed  in  32  seed word, sampled in the SEED state.
REQ-006 Port seed_load  in  1  reseed request pulse, honoured in any state.
REQ-007 Port busy  out  1  high while in SEED or WARM.
REQ-008 Port out0_data / out1_data  out  32  uniform word for requester 0 / 1.
REQ-009 Port out0_valid / out1_valid  out  1  word present on the matching data port.
REQ-010 Port out0_ready / out1_ready  in  1  requester accepts the word this cycle.
REQ-011 Port gen_count  out  16  count of words delivered to both requesters; wraps from 0xFFFF to 0.

Function
REQ-012 FSM states SEED, WARM, RUN; reset enters SEED.
REQ-013 SEED lasts one cycle and loads s0=seed, s1=seed^0x10850089, s2=seed^0x89305309.
REQ-014 Any loaded component below its bound (s0<2, s1<8, s2<16) is ORed with 0x00000100 before storing.
REQ-015 SEED moves to WARM unconditionally; the step counter is cleared.
REQ-016 WARM advances the generator one step per cycle for exactly WARMUP cycles and discards the results, then moves to RUN.
REQ-017 Generator step: three-component Tausworthe with shifts (13,19,12, mask 0xFFFFFFFE), (2,25,4, mask 0xFFFFFFF8), (3,11,17, mask 0xFFFFFFF0); word = s0^s1^s2 of the updated state.
REQ-018 Each requester has one output register; a slot is free when its valid is low or when valid and ready are both high.
REQ-019 In RUN, the generator advances at most once per cycle, and only when at least one slot is free; the word is written to exactly one free slot.
REQ-020 With both slots free, the slot holding round-robin priority is filled, and priority passes to the other slot.
REQ-021 With one slot free, that slot is filled and priority is unchanged.
REQ-022 out*_data holds stable while valid is high and ready is low.
REQ-023 A word is delivered when valid and ready are both high; gen_count increments by the number of words delivered that cycle (0, 1 or 2).
REQ-024 The first word appears on an output one cycle after RUN is entered.
REQ-025 Total throughput is one word per cycle; simultaneous acceptance on both ports leaves one slot empty for the next cycle.
REQ-026 A seed_load in any state moves the FSM to SEED on the next edge, clears both valids and sets busy; gen_count is not cleared.
REQ-027 A seed_load in SEED restarts SEED and resamples seed.
REQ-028 The generator never steps in SEED.
REQ-029 A word generated but never accepted before a reseed is discarded; no word is duplicated or reordered.

Reset
REQ-030 Reset asserted: state=SEED, s0/s1/s2=0, both valids=0, both data=0, busy=1, gen_count=0, priority=ROT_INIT, step counter=0.
REQ-031 Reset is asserted asynchronously; deassertion is assumed synchronised externally; SEED executes on the first edge after deassertion.

Structure
REQ-032 A shared package holds the FSM state typedef, the seed XOR constants, the component bounds and masks, and the 0x100 fix-up constant.
REQ-033 A single sub-module urng_step holds the registered three-component state with load and step-enable inputs; the FSM and arbitration sit in urng_sched.

Verification
REQ-034 Release reset with seed=0x12345678 and WARMUP=16 -> busy high for 17 cycles; first valid on the following cycle; words match a golden model from step 17 onward.
REQ-035 Both ready held high -> words alternate out0, out1, starting at ROT_INIT; one word per cycle; gen_count increments by 1 each cycle.
REQ-036 out0_ready=0 for 10 cycles with out1_ready=1 -> out0_data constant; out1 receives 10 consecutive golden words.
REQ-037 seed_load with seed=0x00000000 in RUN -> valids drop next cycle; stored s0=0x00000100, s1=0x10850089, s2=0x89305309; busy high again for 1+WARMUP cycles.
REQ-038 Reset asserted mid-WARM -> every output takes its REQ-030 value immediately; a full SEED/WARM sequence follows after release.
REQ-039 Run 65537 deliveries -> gen_count wraps from 0xFFFF to 0x0000 and reads 0x0001.
